// File: rtl/wb_uart_slave.sv
// wb_uart_slave
//   Wishbone classic slave wrapping a small UART: a TX FIFO feeding a
//   transmit FSM and, optionally, a receive FSM with a single holding register.
//
// Register map (byte address, only bits [3:2] decoded):
//   0x0 TXDATA  (W)     push byte S_DAT_I[7:0] when S_SEL_I[0]; reads as 0
//   0x4 RXDATA  (R)     {23'b0, rx_valid, rx_byte}; reading clears rx_valid
//   0x8 STATUS  (R/W1C) [0] tx_full [1] tx_empty [2] tx_busy [3] rx_valid
//                       [4] rx_overrun [5] frame_err [6] tx_ovf; W1C on [6:4]
//   0xC DIVISOR (R/W)   bits [15:0]; bit period = DIVISOR+1 clocks
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset (deassertion synchronised outside)
//   S_ADR_I, S_DAT_I, S_DAT_O, S_WE_I, S_STB_I, S_CYC_I, S_SEL_I, S_ACK_O
//              Wishbone classic slave port; one-cycle ack after each request
//   uart_tx_o  serial transmit line, idle high, registered
//   uart_rx_i  serial receive line, asynchronous to clk_i
//   irq_o      level interrupt: rx_valid | (tx_empty & ~tx_busy)
//
// Configuration:
//   UART_RX_EN  when defined, compiles in the receiver. When undefined,
//               uart_rx_i is ignored and the RX status/data read as 0.
//
// States (TX and RX FSMs share the same shape):
//   state | meaning
//   IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
//   START | start bit; RX re-checks it half a bit in and aborts if high
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit; TX chains straight into the next byte if one is queued

module wb_uart_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] DIV_RESET  = 16'd433,
    parameter int          TX_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   S_ADR_I,
    input  logic [DATA_WIDTH-1:0]   S_DAT_I,
    output logic [DATA_WIDTH-1:0]   S_DAT_O,
    input  logic                    S_WE_I,
    input  logic                    S_STB_I,
    input  logic                    S_CYC_I,
    input  logic [DATA_WIDTH/8-1:0] S_SEL_I,
    output logic                    S_ACK_O,
    output logic                    uart_tx_o,
    input  logic                    uart_rx_i,
    output logic                    irq_o
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(TX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  req;
    logic [1:0]            reg_sel;
    logic                  wr_tx, rd_rx, wr_st, wr_div;
    logic [31:0]           rd_data;

    assign req     = S_STB_I & S_CYC_I & ~ack_q;
    assign reg_sel = S_ADR_I[3:2];
    assign wr_tx   = req &  S_WE_I & (reg_sel == 2'd0) & S_SEL_I[0];
    assign rd_rx   = req & ~S_WE_I & (reg_sel == 2'd1);
    assign wr_st   = req &  S_WE_I & (reg_sel == 2'd2) & S_SEL_I[0];
    assign wr_div  = req &  S_WE_I & (reg_sel == 2'd3);

    logic unused_bits;

    // ------------------------------------------------------------------
    // Registers and status
    // ------------------------------------------------------------------
    logic [15:0] div_q;
    logic        tx_ovf_q;
    logic        tx_full, tx_empty, tx_busy;
    logic        rx_valid, rx_ovr, frame_err;
    logic [7:0]  rx_byte;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]  fifo_q [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          tx_pop, push_ok, ovf_set;

    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_q;

    assign tx_full  = (count_q == DEPTH_C);
    assign tx_empty = (count_q == '0);
    assign tx_busy  = (tx_state_q != TX_IDLE);

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // alongside a pop is accepted rather than counted as an overflow.
    assign tx_pop  = ~tx_empty & ((tx_state_q == TX_IDLE) |
                                  ((tx_state_q == TX_STOP) & (tx_cnt_q == '0)));
    assign push_ok = wr_tx & (~tx_full | tx_pop);
    assign ovf_set = wr_tx & tx_full & ~tx_pop;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= S_DAT_I[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, tx_pop};
        end
    end

    // ------------------------------------------------------------------
    // TX FSM; the bit timer reloads from div_q at every bit boundary
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_cnt_q   <= div_q;
                        tx_shift_q <= fifo_q[rd_ptr_q];
                        tx_q       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= div_q;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= div_q;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_q       <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        if (tx_pop) begin
                            tx_state_q <= TX_START;
                            tx_cnt_q   <= div_q;
                            tx_shift_q <= fifo_q[rd_ptr_q];
                            tx_q       <= 1'b0;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign uart_tx_o = tx_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic [1:0]  rx_sync_q;
    logic        rx_prev_q;
    logic        rx_s;
    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, rx_byte_q;
    logic        rx_valid_q, rx_ovr_q, frame_err_q;
    logic [15:0] rx_half, rx_half_ld;

    assign rx_s = rx_sync_q[1];
    // (DIVISOR+1)/2 without a 17-bit add; the timer counts ld..0 inclusive.
    assign rx_half    = {1'b0, div_q[15:1]} + {15'b0, div_q[0]};
    assign rx_half_ld = (rx_half == '0) ? '0 : rx_half - 16'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_q   <= 2'b11;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], uart_rx_i};
            rx_prev_q <= rx_s;
            if (rd_rx)                rx_valid_q  <= 1'b0;
            if (wr_st && S_DAT_I[4])  rx_ovr_q    <= 1'b0;
            if (wr_st && S_DAT_I[5])  frame_err_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= rx_half_ld;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_s) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= div_q;
                            rx_bit_q   <= '0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        rx_cnt_q   <= div_q;
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) begin
                        // A bad stop bit still delivers the byte, flagged.
                        rx_byte_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        if (rx_valid_q && !rd_rx) rx_ovr_q <= 1'b1;
                        if (!rx_s) frame_err_q <= 1'b1;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid  = rx_valid_q;
    assign rx_ovr    = rx_ovr_q;
    assign frame_err = frame_err_q;
    assign rx_byte   = rx_byte_q;
    assign unused_bits = ^{S_ADR_I, S_DAT_I, S_SEL_I};
`else
    assign rx_valid  = 1'b0;
    assign rx_ovr    = 1'b0;
    assign frame_err = 1'b0;
    assign rx_byte   = 8'h00;
    assign unused_bits = ^{S_ADR_I, S_DAT_I, S_SEL_I, uart_rx_i};
`endif

    // ------------------------------------------------------------------
    // Read mux and bus-side registers
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd1:    rd_data = {23'b0, rx_valid, rx_byte};
            2'd2:    rd_data = {25'b0, tx_ovf_q, frame_err, rx_ovr, rx_valid,
                                tx_busy, tx_empty, tx_full};
            2'd3:    rd_data = {16'b0, div_q};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            div_q    <= DIV_RESET;
            tx_ovf_q <= 1'b0;
        end else begin
            ack_q <= req;
            // Read data is only driven during the ack cycle.
            dat_q <= (req && !S_WE_I) ? DATA_WIDTH'(rd_data) : '0;
            if (wr_div) begin
                if (S_SEL_I[0]) div_q[7:0]  <= S_DAT_I[7:0];
                if (S_SEL_I[1]) div_q[15:8] <= S_DAT_I[15:8];
            end
            if (wr_st && S_DAT_I[6]) tx_ovf_q <= 1'b0;
            if (ovf_set)             tx_ovf_q <= 1'b1;
        end
    end

    assign S_ACK_O = ack_q;
    assign S_DAT_O = dat_q;
    assign irq_o   = rx_valid | (tx_empty & ~tx_busy);

endmodule

// File: tb/tb_wb_uart_slave.sv
module tb_wb_uart_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr, dat_i, dat_o;
    logic        we, stb, cyc;
    logic [3:0]  sel;
    logic        ack, tx, rx, irq;

    always #5 clk = ~clk;

    wb_uart_slave dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .S_ADR_I  (adr),
        .S_DAT_I  (dat_i),
        .S_DAT_O  (dat_o),
        .S_WE_I   (we),
        .S_STB_I  (stb),
        .S_CYC_I  (cyc),
        .S_SEL_I  (sel),
        .S_ACK_O  (ack),
        .uart_tx_o(tx),
        .uart_rx_i(rx),
        .irq_o    (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q  [$];
    bit          chk_q  [$];
    string       name_q [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack consumes one queued expectation.
    logic [31:0] mon_e;
    bit          mon_c;
    string       mon_n;
    always @(negedge clk) begin
        if (rst_n && ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = chk_q.pop_front();
                mon_n = name_q.pop_front();
                if (mon_c) check(mon_n, {32'b0, dat_o}, {32'b0, mon_e});
            end
        end
    end

    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e, input string nm);
        bit got;
        exp_q.push_back(e);
        chk_q.push_back(!w);
        name_q.push_back(nm);
        @(posedge clk); #1;
        adr = a; dat_i = d; we = w; sel = s; stb = 1'b1; cyc = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            got = ack;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) check({nm, "_ack_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wb(1'b1, a, d, s, 32'h0, "write");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        wb(1'b0, a, 32'h0, 4'hF, e, nm);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_clks);
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (bit_clks) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bit_clks) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (bit_clks) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("reset_tx_async", {63'b0, tx}, 64'd1);
        check("reset_ack", {63'b0, ack}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [47:0] line_got, line_exp;
    logic [7:0]  byte_v;
    int          busy_clks, lows, acks;

    initial begin
        adr = '0; dat_i = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; sel = '0; rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {63'b0, ack}, 64'd0);
        check("reset_dat", {32'b0, dat_o}, 64'd0);
        check("reset_tx", {63'b0, tx}, 64'd1);
        rst_n = 1'b1;

        rd(32'h8, 32'h02, "status_reset");
        rd(32'hC, 32'd433, "div_reset");
        rd(32'h0, 32'h0, "txdata_reads_zero");

        // Per-byte divisor writes: 433 = 0x01B1
        wr(32'hC, 32'h0000_ABCD, 4'b0001);
        rd(32'hC, 32'h01CD, "div_sel_byte0");
        wr(32'hC, 32'h0000_1234, 4'b0010);
        rd(32'hC, 32'h12CD, "div_sel_byte1");
        wr(32'hC, 32'd3, 4'hF);
        rd(32'hC, 32'd3, "div_3");

        // 0xA5 frame at 4 clocks per bit
        wr(32'h0, 32'hA5, 4'h1);
        busy_clks = 0;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk); #1;
            line_got[i] = tx;
            if (!irq) busy_clks++;
        end
        byte_v = 8'hA5;
        for (int i = 0; i < 48; i++) begin
            if (i < 4)       line_exp[i] = 1'b0;
            else if (i < 36) line_exp[i] = byte_v[(i-4)/4];
            else             line_exp[i] = 1'b1;
        end
        check("tx_waveform_a5", {16'b0, line_got}, {16'b0, line_exp});
        check("tx_busy_clocks", 64'(busy_clks), 64'd40);
        rd(32'h8, 32'h02, "status_after_frame");

`ifndef UART_RX_EN
        rd(32'h4, 32'h0, "rxdata_disabled");
`endif

        // FIFO fill with transmitter stalled on a long bit
        wr(32'hC, 32'hFFFF, 4'h3);
        for (int v = 1; v <= 5; v++) wr(32'h0, 32'(v), 4'h1);
        rd(32'h8, 32'h05, "status_full");
        check("irq_while_busy", {63'b0, irq}, 64'd0);
        wr(32'h0, 32'h06, 4'h1);
        rd(32'h8, 32'h45, "status_tx_ovf");
        wr(32'h8, 32'h40, 4'h1);
        rd(32'h8, 32'h05, "status_ovf_cleared");

        do_reset();
        rd(32'h8, 32'h02, "status_after_reset1");

        // Reset during the DATA state of a 0x00 frame
        wr(32'hC, 32'd3, 4'hF);
        wr(32'h0, 32'h00, 4'h1);
        repeat (10) @(posedge clk);
        #1;
        check("tx_mid_data_low", {63'b0, tx}, 64'd0);
        do_reset();
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (!tx) lows++;
        end
        check("no_resend_after_reset", 64'(lows), 64'd0);
        rd(32'h8, 32'h02, "status_after_reset2");
        rd(32'hC, 32'd433, "div_after_reset");

        // STB/CYC held for six cycles on a STATUS read
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h02);
            chk_q.push_back(1'b1);
            name_q.push_back("held_status_read");
        end
        @(posedge clk); #1;
        adr = 32'h8; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) acks++;
            else check("dat_zero_between_acks", {32'b0, dat_o}, 64'd0);
        end
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        check("held_ack_count", 64'(acks), 64'd3);

`ifdef UART_RX_EN
        wr(32'hC, 32'd7, 4'hF);
        send_frame(8'h3C, 8);
        repeat (10) @(posedge clk);
        rd(32'h8, 32'h0A, "status_rx_valid");
        rd(32'h4, 32'h13C, "rxdata_3c");
        rd(32'h8, 32'h02, "status_rx_cleared");
        send_frame(8'h11, 8);
        send_frame(8'h22, 8);
        repeat (10) @(posedge clk);
        rd(32'h8, 32'h1A, "status_overrun");
        rd(32'h4, 32'h122, "rxdata_22");
        wr(32'h8, 32'h10, 4'h1);
        rd(32'h8, 32'h02, "status_overrun_cleared");
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        rd(32'h8, 32'h02, "status_after_glitch");
        rd(32'h4, 32'h022, "rxdata_after_glitch");
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
